ring_freq_meter: RTL and testbench



---
 rtl/ring_meter_pkg.sv | 6 +
 rtl/sync_edge_detect.sv | 16 +
 rtl/ring_freq_meter.sv | 97 +++++++++
 tb/tb_ring_freq_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ring_meter_pkg.sv
// ring_meter_pkg: shared FSM state type and fixed timing constants for the ring frequency meter.
package ring_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_e;
  localparam int ARM_CYCLES  = 2;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous tap into the clk domain and emits a one-cycle rise pulse.
module sync_edge_detect
  import ring_meter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);
  // Two synchronizer stages plus one history flop for the edge compare.
  logic [SYNC_STAGES:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-1:0], async_i};
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
endmodule

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts rising edges of an async ring-oscillator tap over a 2**GATE_LOG2-cycle gate.
module ring_freq_meter
  import ring_meter_pkg::*;
#(
  parameter int GATE_LOG2 = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             sample_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);
  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  state_e               state_q;
  logic [ARM_W-1:0]     arm_q;
  logic [GATE_LOG2-1:0] gate_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d, count_q;
  logic                 ovf_q, ovf_d, overflow_q, valid_q, busy_q;
  logic                 rise, sat;
  sync_edge_detect u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(sample_in),
    .rise_o (rise)
  );
  // An edge arriving while the counter is already full is a lost edge: hold and flag it.
  always_comb begin
    sat   = &cnt_q;
    cnt_d = (rise && !sat) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = ovf_q | (rise & sat);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      arm_q      <= '0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!ena) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start || continuous) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            arm_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
          ARM: begin
            arm_q <= arm_q + ARM_W'(1);
            if (arm_q == ARM_W'(ARM_CYCLES - 1)) begin
              state_q <= GATE;
              gate_q  <= '0;
            end
          end
          GATE: begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            gate_q <= gate_q + GATE_LOG2'(1);
            if (&gate_q) begin
              state_q    <= DONE;
              count_q    <= cnt_d;
              overflow_q <= ovf_d;
              valid_q    <= 1'b1;
            end
          end
          DONE: begin
            state_q <= continuous ? ARM : IDLE;
            busy_q  <= continuous;
            arm_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign count    = count_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: random and directed stimulus checked against a window-level edge-count model.
module tb_ring_freq_meter;
  localparam int N = 16;
  logic clk = 0, reset_n = 0, ena = 0, sample_in = 0, start = 0, continuous = 0;
  logic [15:0] count;
  logic        valid, overflow, busy;
  logic [1:0]  count2;
  logic        valid2, overflow2, busy2;
  ring_freq_meter #(.GATE_LOG2(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .sample_in(sample_in), .start(start),
    .continuous(continuous), .count(count), .valid(valid), .overflow(overflow), .busy(busy));
  ring_freq_meter #(.GATE_LOG2(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .sample_in(sample_in), .start(start),
    .continuous(continuous), .count(count2), .valid(valid2), .overflow(overflow2), .busy(busy2));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Input pattern: 0 hold, d>0 toggle every d cycles, <0 random level each cycle.
  int tog = 0, tcnt = 0;
  always @(negedge clk) begin
    if (tog > 0) begin
      tcnt++;
      if (tcnt >= tog) begin
        tcnt = 0;
        sample_in = ~sample_in;
      end
    end else if (tog < 0) sample_in = 1'($urandom_range(0, 1));
  end
  // Model: input history per clock edge; a measurement is a window of edge offsets from its start.
  logic hist[0:65535];
  int   e = 0, rbase = 0, k = 0, edges = 0, off = 0;
  bit   rst_seen = 1, active = 0;
  logic [15:0] m_cnt = 0;
  logic [1:0]  m_cnt2 = 0;
  logic        m_ovf2 = 0, m_valid = 0;
  function automatic logic h(input int i);
    return (i >= 0 && i >= rbase) ? hist[i] : 1'b0;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_seen = 1;
      active   = 0;
      m_cnt    = 0;
      m_cnt2   = 0;
      m_ovf2   = 0;
      m_valid  = 0;
    end else begin
      e++;
      hist[e] = sample_in;
      if (rst_seen) begin
        rbase    = e;
        rst_seen = 0;
      end
      m_valid = 0;
      if (!active) begin
        if (ena && (start || continuous)) begin
          active = 1;
          k      = e;
          edges  = 0;
        end
      end else if (!ena) active = 0;
      else begin
        off = e - k;
        if (off >= 3 && off <= N + 2 && h(e - 2) && !h(e - 3)) edges++;
        if (off == N + 2) begin
          m_valid = 1;
          m_cnt   = 16'(edges);
          m_cnt2  = 2'(edges > 3 ? 3 : edges);
          m_ovf2  = edges > 3;
        end
        if (off == N + 3) begin
          if (continuous) begin
            k     = e;
            edges = 0;
          end else active = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (reset_n) begin
      check("valid", valid, m_valid);
      check("busy", busy, active);
      check("count", count, m_cnt);
      check("overflow", overflow, 0);
      check("valid2", valid2, m_valid);
      check("busy2", busy2, active);
      check("count2", count2, m_cnt2);
      check("overflow2", overflow2, m_ovf2);
    end
  end
  task automatic run(input int window, input int restart_at, output int lat, output int nv,
                     output logic b1, output logic b_end);
    lat = -1;
    nv  = 0;
    b1  = 0;
    b_end = 1;
    start = 1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (valid) begin
        nv++;
        if (lat < 0) lat = i;
      end
      if (i == 1) b1 = busy;
      if (i == 20) b_end = busy;
    end
  endtask
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (valid) begin
        n = i;
        return;
      end
    end
  endtask
  task automatic quiet(input int cycles, output int nv, output int nb);
    nv = 0;
    nb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) nv++;
      if (busy) nb++;
    end
  endtask
  int lat, nv, nb, gap;
  logic b1, b_end;
  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset_n = 1;
    ena = 1;
    tog = 2;
    repeat (4) @(negedge clk);
    run(40, -1, lat, nv, b1, b_end);
    check("t1_latency", lat, 19);
    check("t1_nvalid", nv, 1);
    check("t1_count", count, 4);
    check("t1_overflow", overflow, 0);
    check("t1_busy_first", b1, 1);
    check("t1_busy_after", b_end, 0);
    check("t1_count2", count2, 3);
    check("t1_overflow2", overflow2, 1);
    tog = 1;
    run(30, -1, lat, nv, b1, b_end);
    check("t2_count", count, 8);
    check("t2_count2", count2, 3);
    check("t2_overflow2", overflow2, 1);
    tog = 0;
    repeat (4) @(negedge clk);
    run(30, -1, lat, nv, b1, b_end);
    check("t2_static_count2", count2, 0);
    check("t2_static_overflow2", overflow2, 0);
    tog = 4;
    repeat (4) @(negedge clk);
    continuous = 1;
    wait_valid(40, gap);
    check("t3_first_seen", gap > 0, 1);
    wait_valid(40, gap);
    check("t3_period_a", gap, 19);
    check("t3_count_a", count, 2);
    wait_valid(40, gap);
    check("t3_period_b", gap, 19);
    check("t3_count_b", count, 2);
    repeat (8) @(negedge clk);
    continuous = 0;
    wait_valid(25, gap);
    check("t3_finish_gap", gap, 11);
    check("t3_finish_count", count, 2);
    quiet(40, nv, nb);
    check("t3_idle_valids", nv, 0);
    check("t3_idle_busy", nb, 0);
    tog = 2;
    repeat (4) @(negedge clk);
    run(30, -1, lat, nv, b1, b_end);
    check("t4_prior_count", count, 4);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    check("t4_busy_in_gate", busy, 1);
    ena = 0;
    @(negedge clk);
    check("t4_busy_abort", busy, 0);
    check("t4_count_kept", count, 4);
    ena = 1;
    quiet(30, nv, nb);
    check("t4_no_valid", nv, 0);
    run(40, 8, lat, nv, b1, b_end);
    check("t5_latency", lat, 19);
    check("t5_nvalid", nv, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("t6_count", count, 0);
    check("t6_valid", valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;
    quiet(30, nv, nb);
    check("t6_idle_valid", nv, 0);
    check("t6_idle_busy", nb, 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 400 == 0) tog = int'($urandom_range(0, 5)) - 1;
      ena   = $urandom_range(0, 99) > 3;
      start = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 29) == 0) continuous = ~continuous;
      if ($urandom_range(0, 599) == 0) begin
        #3 reset_n = 0;
        @(negedge clk);
        reset_n = 1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
